oam_dma: RTL and testbench

// - Sprite DMA controller ($4014). On a CPU write of page P it halts the CPU, reads
//   $P00..$PFF on the CPU bus and writes each byte into OAM through the $2004 data path.
// - Feeds the PPU's OAM data/write port; the PPU's OAM address increments once per write.
// - Sits between the CPU bus, the APU/DMC sample fetcher and the PPU register block.
//

---
 rtl/ppu_pkg.sv | 28 ++
 rtl/oam_dma_if.sv | 51 +++++
 rtl/oam_dma.sv | 146 ++++++++++++++
 tb/tb_oam_dma.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
//------------------------------------------------------------------------------
// ppu_pkg : shared PPU-side types and addresses (sprite DMA state, register map)
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package ppu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_DUMMY = 3'd2,
        ST_ALIGN = 3'd3,
        ST_READ  = 3'd4,
        ST_WRITE = 3'd5
    } dma_state_t;

    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] DMA_PAGE_REG  = 16'h4014;

    // Get/put toggle encoding; GET is the reset value.
    localparam logic PH_GET = 1'b0;
    localparam logic PH_PUT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/oam_dma_if.sv
//------------------------------------------------------------------------------
// oam_dma_if : CPU-bus / OAM port bundle for the sprite DMA controller.
// Optional macro OAM_DMA_DMC_EN adds the DMC sample-fetch steal signals.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface oam_dma_if;

    logic        cpu_ce;
    logic        cpu_rw;
    logic        dma_wr;
    logic [7:0]  dma_page;
    logic [7:0]  bus_data_i;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  oam_data_o;
    logic        oam_data_wr;
    logic        busy;
`ifdef OAM_DMA_DMC_EN
    logic        dmc_req;
    logic [15:0] dmc_addr;
    logic        dmc_ack;

    modport master (
        input  cpu_ce, cpu_rw, dma_wr, dma_page, bus_data_i, dmc_req, dmc_addr,
        output cpu_halt, bus_addr, bus_rd, bus_wr, oam_data_o, oam_data_wr, busy, dmc_ack
    );

    modport slave (
        output cpu_ce, cpu_rw, dma_wr, dma_page, bus_data_i, dmc_req, dmc_addr,
        input  cpu_halt, bus_addr, bus_rd, bus_wr, oam_data_o, oam_data_wr, busy, dmc_ack
    );
`else
    modport master (
        input  cpu_ce, cpu_rw, dma_wr, dma_page, bus_data_i,
        output cpu_halt, bus_addr, bus_rd, bus_wr, oam_data_o, oam_data_wr, busy
    );

    modport slave (
        output cpu_ce, cpu_rw, dma_wr, dma_page, bus_data_i,
        input  cpu_halt, bus_addr, bus_rd, bus_wr, oam_data_o, oam_data_wr, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
//------------------------------------------------------------------------------
// oam_dma : $4014 sprite DMA - halts the CPU and copies page $P00..$PFF into OAM.
// Optional macro OAM_DMA_DMC_EN lets DMC sample fetches steal GET slots.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module oam_dma #(
    parameter logic [15:0] OAM_DATA_ADDR = ppu_pkg::OAM_DATA_ADDR
) (
    input  wire logic clk,
    input  wire logic rst,
    oam_dma_if.master bus
);

    import ppu_pkg::*;

    dma_state_t  state;
    dma_state_t  state_d;
    logic        phase;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_q;

    logic        load;
    logic        capture;
    logic        advance;
    logic        halt;
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic        oam_wr;
`ifdef OAM_DMA_DMC_EN
    logic        dmc_ack;
`endif

    // Every register moves only on a CPU-cycle boundary; reset overrides that.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            phase  <= PH_GET;
            page   <= 8'h00;
            idx    <= 8'h00;
            data_q <= 8'h00;
        end else if (bus.cpu_ce) begin
            state <= state_d;
            phase <= ~phase;
            if (load) begin
                page <= bus.dma_page;
                idx  <= 8'h00;
            end
            if (capture) begin
                data_q <= bus.bus_data_i;
            end
            if (advance) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        halt    = 1'b0;
        addr    = 16'h0000;
        rd      = 1'b0;
        wr      = 1'b0;
        oam_wr  = 1'b0;
`ifdef OAM_DMA_DMC_EN
        dmc_ack = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.dma_wr) begin
                    load    = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                halt = 1'b1;
                // The 6502 can only be stopped on a read cycle.
                if (bus.cpu_rw) begin
                    state_d = ST_DUMMY;
                end
            end
            ST_DUMMY: begin
                halt    = 1'b1;
                state_d = (~phase == PH_GET) ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                halt    = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                halt = 1'b1;
`ifdef OAM_DMA_DMC_EN
                if (bus.dmc_req) begin
                    // DMC takes this get slot; the following put idles via ALIGN.
                    addr    = bus.dmc_addr;
                    rd      = 1'b1;
                    dmc_ack = 1'b1;
                    state_d = ST_ALIGN;
                end else begin
                    addr    = {page, idx};
                    rd      = 1'b1;
                    capture = 1'b1;
                    state_d = ST_WRITE;
                end
`else
                addr    = {page, idx};
                rd      = 1'b1;
                capture = 1'b1;
                state_d = ST_WRITE;
`endif
            end
            ST_WRITE: begin
                halt    = 1'b1;
                addr    = OAM_DATA_ADDR;
                wr      = 1'b1;
                oam_wr  = 1'b1;
                advance = 1'b1;
                state_d = (idx == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.cpu_halt    = halt;
    assign bus.bus_addr    = addr;
    assign bus.bus_rd      = rd;
    assign bus.bus_wr      = wr;
    assign bus.oam_data_o  = data_q;
    assign bus.oam_data_wr = oam_wr & bus.cpu_ce;
    assign bus.busy        = (state != ST_IDLE);
`ifdef OAM_DMA_DMC_EN
    assign bus.dmc_ack     = dmc_ack;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
//------------------------------------------------------------------------------
// tb_oam_dma : randomized scoreboard bench for the sprite DMA controller.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_oam_dma;

    logic clk = 1'b0;
    logic rst = 1'b1;

    oam_dma_if bus();

    oam_dma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:65535];
    assign bus.bus_data_i = mem[bus.bus_addr];

    logic [15:0] rdq [$];
    logic [7:0]  wq  [$];
    int          durq[$];

    int errors  = 0;
    int checks  = 0;
    int wr_seen = 0;
    int hold    = 0;
    int n       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual=%0h required=nothing pending", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a bus event.
    always @(negedge clk) begin
        if (rst) begin
            hold = 0;
        end else if (!bus.cpu_ce) begin
            chk("wr_without_ce", {31'd0, bus.oam_data_wr}, 32'd0);
        end else begin
            if (bus.cpu_halt) begin
                hold++;
            end else if (hold > 0) begin
                if (durq.size() == 0) miss("halt_cycles", hold);
                else chk("halt_cycles", hold, durq.pop_front());
                hold = 0;
            end
            if (!bus.busy) begin
                chk("idle_addr", {16'd0, bus.bus_addr}, 32'd0);
                chk("idle_ctl", {29'd0, bus.bus_rd, bus.bus_wr, bus.cpu_halt}, 32'd0);
            end
            if (bus.bus_rd) begin
                if (rdq.size() == 0) miss("read_addr", {16'd0, bus.bus_addr});
                else chk("read_addr", {16'd0, bus.bus_addr}, {16'd0, rdq.pop_front()});
            end
            if (bus.oam_data_wr) begin
                wr_seen++;
                chk("put_addr", {15'd0, bus.bus_wr, bus.bus_addr}, {15'd0, 1'b1, 16'h2004});
                if (wq.size() == 0) miss("oam_data", {24'd0, bus.oam_data_o});
                else chk("oam_data", {24'd0, bus.oam_data_o}, {24'd0, wq.pop_front()});
            end
        end
    end

    // One CPU cycle: random number of stalled clocks, then a cpu_ce clock.
    task automatic cyc(input logic rw, input logic wr, input logic [7:0] pg);
        int gap;
        gap = $urandom_range(0, 2);
        bus.cpu_rw   = rw;
        bus.dma_wr   = wr;
        bus.dma_page = pg;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.cpu_ce = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_ce = 1'b0;
        bus.dma_wr = 1'b0;
        n++;
    endtask

    // Expected behaviour: cycle parity from reset gives get (even) / put (odd).
    // After the $4014 write at cycle t and k CPU write cycles, the first read
    // slot must be even; one halted cycle + dummy + optional align + 512 transfers.
    task automatic queue_expect(input logic [7:0] pg, input int k);
        int al;
        al = (n + k + 3) % 2;
        for (int i = 0; i < 256; i++) begin
            rdq.push_back({pg, 8'(i)});
            wq.push_back(mem[{pg, 8'(i)}]);
        end
        durq.push_back((k + 1) + 1 + al + 512);
    endtask

    task automatic run_dma(input logic [7:0] pg, input int k, input int want_align, input bit mid_wr);
        int c;
        if (want_align >= 0) begin
            while (((n + k + 3) % 2) != want_align) cyc(1'b1, 1'b0, 8'h00);
        end
        queue_expect(pg, k);
        cyc(1'b0, 1'b1, pg);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 8'h00);
        c = 0;
        while (bus.busy && c < 1500) begin
            cyc(1'b1, mid_wr && (c == 40), 8'h33);
            c++;
        end
        if (bus.busy) begin
            miss("dma_timeout", c);
        end
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int base;
        int c;
        bus.cpu_ce   = 1'b0;
        bus.cpu_rw   = 1'b1;
        bus.dma_wr   = 1'b0;
        bus.dma_page = 8'h00;
`ifdef OAM_DMA_DMC_EN
        bus.dmc_req  = 1'b0;
        bus.dmc_addr = 16'h0000;
`endif
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_halt",  {31'd0, bus.cpu_halt},    32'd0);
        chk("rst_busy",  {31'd0, bus.busy},        32'd0);
        chk("rst_rd",    {31'd0, bus.bus_rd},      32'd0);
        chk("rst_wr",    {31'd0, bus.bus_wr},      32'd0);
        chk("rst_oamwr", {31'd0, bus.oam_data_wr}, 32'd0);
        chk("rst_addr",  {16'd0, bus.bus_addr},    32'd0);
        chk("rst_data",  {24'd0, bus.oam_data_o},  32'd0);

        repeat (4) cyc(1'b1, 1'b0, 8'h00);
        run_dma(8'h02, 0, 0, 1'b0);
        run_dma(8'h02, 0, 1, 1'b0);
        run_dma(8'h02, 2, -1, 1'b0);
        run_dma(8'hFF, 0, -1, 1'b1);
        for (int r = 0; r < 3; r++) begin
            run_dma(8'($urandom), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        // Abort after the 100th OAM write, then prove a fresh transfer works.
        base = wr_seen;
        queue_expect(8'h40, 0);
        cyc(1'b0, 1'b1, 8'h40);
        c = 0;
        while (wr_seen < base + 100 && c < 400) begin
            cyc(1'b1, 1'b0, 8'h00);
            c++;
        end
        if (wr_seen < base + 100) miss("abort_timeout", c);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdq.delete();
        wq.delete();
        durq.delete();
        n = 0;
        chk("abort_halt", {31'd0, bus.cpu_halt}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy},     32'd0);
        base = wr_seen;
        repeat (20) cyc(1'b1, 1'b0, 8'h00);
        chk("abort_no_writes", wr_seen, base);
        run_dma(8'h07, 1, -1, 1'b0);

        chk("rdq_drained",  rdq.size(),  32'd0);
        chk("wq_drained",   wq.size(),   32'd0);
        chk("durq_drained", durq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
